// File: rtl/sram_fifo_arbiter.sv
// rtl/sram_fifo_arbiter.sv - two SRAM-backed FIFOs sharing one async SRAM, round-robin arbitrated
//
// Purpose:
//   fifo_i carries words from the SPI slave side to the SPI master side, fifo_o
//   carries words the other way. Both FIFOs live in disjoint regions of a single
//   external asynchronous SRAM, so only one SRAM access runs at a time. Four
//   requesters (SW, SR, MW, MR) compete for it under a rotating-priority arbiter.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   slave_write / slave_read  level requests from the slave side (push fifo_i / pop fifo_o)
//   master_write / master_read level requests from the master side (push fifo_o / pop fifo_i)
//   slave_wdata, master_wdata write data, latched when the request is granted
//   slave_rdata, master_rdata read data, held until the next read on that side
//   slave_ack, master_ack     one-cycle completion pulses
//   fifo_i_* / fifo_o_*       occupancy and empty/full/almost-full flags
//   mem_addr, mem_dq          SRAM address and bidirectional data bus
//   CE_n, OE_n, WE_n, LB_n, UB_n  SRAM controls, active low

module sram_fifo_arbiter #(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 18,
  parameter int FI_BASE       = 0,
  parameter int FI_DEPTH_LOG2 = 17,
  parameter int FO_BASE       = 131072,
  parameter int FO_DEPTH_LOG2 = 17,
  parameter int ACCESS_CYCLES = 1,
  parameter int AFULL_LEVEL   = 2**17 - 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     slave_write,
  input  logic                     slave_read,
  input  logic                     master_write,
  input  logic                     master_read,
  input  logic [DATA_W-1:0]        slave_wdata,
  input  logic [DATA_W-1:0]        master_wdata,
  output logic [DATA_W-1:0]        slave_rdata,
  output logic [DATA_W-1:0]        master_rdata,
  output logic                     slave_ack,
  output logic                     master_ack,
  output logic                     fifo_i_empty,
  output logic                     fifo_i_full,
  output logic                     fifo_i_afull,
  output logic [FI_DEPTH_LOG2:0]   fifo_i_count,
  output logic                     fifo_o_empty,
  output logic                     fifo_o_full,
  output logic                     fifo_o_afull,
  output logic [FO_DEPTH_LOG2:0]   fifo_o_count,
  output logic [ADDR_W-1:0]        mem_addr,
  inout  wire  [DATA_W-1:0]        mem_dq,
  output logic                     CE_n,
  output logic                     OE_n,
  output logic                     WE_n,
  output logic                     LB_n,
  output logic                     UB_n
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ACCESS  = 3'd2,
    S_RELEASE = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  // Requester ids. Bit 1 selects the side (0 slave, 1 master); bit 0 is set for reads.
  localparam logic [1:0] G_SW = 2'd0;
  localparam logic [1:0] G_SR = 2'd1;
  localparam logic [1:0] G_MW = 2'd2;
  localparam logic [1:0] G_MR = 2'd3;

  localparam logic [2:0]               ACC_LAST   = 3'(ACCESS_CYCLES - 1);
  localparam logic [FI_DEPTH_LOG2:0]   FI_DEPTH   = (FI_DEPTH_LOG2 + 1)'(2**FI_DEPTH_LOG2);
  localparam logic [FO_DEPTH_LOG2:0]   FO_DEPTH   = (FO_DEPTH_LOG2 + 1)'(2**FO_DEPTH_LOG2);
  localparam logic [FI_DEPTH_LOG2:0]   FI_CNT_ONE = (FI_DEPTH_LOG2 + 1)'(1);
  localparam logic [FO_DEPTH_LOG2:0]   FO_CNT_ONE = (FO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FI_DEPTH_LOG2-1:0] FI_PTR_ONE = FI_DEPTH_LOG2'(1);
  localparam logic [FO_DEPTH_LOG2-1:0] FO_PTR_ONE = FO_DEPTH_LOG2'(1);
  localparam logic [ADDR_W-1:0]        FI_BASE_A  = ADDR_W'(FI_BASE);
  localparam logic [ADDR_W-1:0]        FO_BASE_A  = ADDR_W'(FO_BASE);
  localparam logic [31:0]              AFULL_U    = 32'(AFULL_LEVEL);

  state_t                   state_q, state_d;
  logic [1:0]               grant_q, grant_d;
  logic [1:0]               last_q, last_d;
  logic [2:0]               acc_cnt_q, acc_cnt_d;
  logic [FI_DEPTH_LOG2-1:0] fi_wptr_q, fi_wptr_d, fi_rptr_q, fi_rptr_d;
  logic [FO_DEPTH_LOG2-1:0] fo_wptr_q, fo_wptr_d, fo_rptr_q, fo_rptr_d;
  logic [FI_DEPTH_LOG2:0]   fi_count_q, fi_count_d;
  logic [FO_DEPTH_LOG2:0]   fo_count_q, fo_count_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [DATA_W-1:0]        rd_cap_q, rd_cap_d;
  logic [DATA_W-1:0]        slave_rdata_q, slave_rdata_d;
  logic [DATA_W-1:0]        master_rdata_q, master_rdata_d;

  logic [3:0] req;
  logic       arb_valid;
  logic [1:0] arb_id;
  logic [1:0] idx;
  logic       is_write;
  logic       acc_done;
  logic       dq_oe;

  // Flags come straight from the count registers, so they reflect a grant in
  // the cycle right after it.
  assign fifo_i_empty = (fi_count_q == '0);
  assign fifo_i_full  = (fi_count_q == FI_DEPTH);
  assign fifo_i_afull = (32'(fi_count_q) >= AFULL_U);
  assign fifo_o_empty = (fo_count_q == '0);
  assign fifo_o_full  = (fo_count_q == FO_DEPTH);
  assign fifo_o_afull = (32'(fo_count_q) >= AFULL_U);
  assign fifo_i_count = fi_count_q;
  assign fifo_o_count = fo_count_q;

  assign mem_addr     = addr_q;
  assign slave_rdata  = slave_rdata_q;
  assign master_rdata = master_rdata_q;
  assign mem_dq       = dq_oe ? wdata_q : {DATA_W{1'bz}};

  assign is_write = ~grant_q[0];
  assign acc_done = (acc_cnt_q == ACC_LAST);

  // Requests against a full/empty FIFO are simply not eligible; they stay
  // pending until the FIFO state changes.
  assign req[G_SW] = slave_write  & ~fifo_i_full;
  assign req[G_SR] = slave_read   & ~fifo_o_empty;
  assign req[G_MW] = master_write & ~fifo_o_full;
  assign req[G_MR] = master_read  & ~fifo_i_empty;

  // Rotating priority: search starts just after the last granted requester,
  // so the last winner is checked last.
  always_comb begin
    arb_valid = 1'b0;
    arb_id    = last_q;
    idx       = last_q;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!arb_valid && req[idx]) begin
        arb_valid = 1'b1;
        arb_id    = idx;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (arb_valid) state_d = S_SETUP;
      S_SETUP:   state_d = S_ACCESS;
      S_ACCESS:  if (acc_done) state_d = S_RELEASE;
      S_RELEASE: state_d = S_ACK;
      S_ACK:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    CE_n       = 1'b1;
    OE_n       = 1'b1;
    WE_n       = 1'b1;
    LB_n       = 1'b1;
    UB_n       = 1'b1;
    dq_oe      = 1'b0;
    slave_ack  = 1'b0;
    master_ack = 1'b0;
    case (state_q)
      S_SETUP: begin
        CE_n  = 1'b0;
        LB_n  = 1'b0;
        UB_n  = 1'b0;
        dq_oe = is_write;
      end
      S_ACCESS: begin
        CE_n  = 1'b0;
        LB_n  = 1'b0;
        UB_n  = 1'b0;
        dq_oe = is_write;
        WE_n  = ~is_write;
        // The bus is only ever driven on writes, so OE_n low never overlaps dq_oe.
        OE_n  = is_write;
      end
      S_ACK: begin
        slave_ack  = ~grant_q[1];
        master_ack = grant_q[1];
      end
      default: ;
    endcase
  end

  // Datapath: pointer/count bookkeeping happens in the grant cycle so that the
  // flags already reflect the transaction in flight.
  always_comb begin
    grant_d        = grant_q;
    last_d         = last_q;
    acc_cnt_d      = acc_cnt_q;
    fi_wptr_d      = fi_wptr_q;
    fi_rptr_d      = fi_rptr_q;
    fo_wptr_d      = fo_wptr_q;
    fo_rptr_d      = fo_rptr_q;
    fi_count_d     = fi_count_q;
    fo_count_d     = fo_count_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rd_cap_d       = rd_cap_q;
    slave_rdata_d  = slave_rdata_q;
    master_rdata_d = master_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_id;
          last_d  = arb_id;
          case (arb_id)
            G_SW: begin
              addr_d     = FI_BASE_A + ADDR_W'(fi_wptr_q);
              wdata_d    = slave_wdata;
              fi_wptr_d  = fi_wptr_q + FI_PTR_ONE;
              fi_count_d = fi_count_q + FI_CNT_ONE;
            end
            G_SR: begin
              addr_d     = FO_BASE_A + ADDR_W'(fo_rptr_q);
              fo_rptr_d  = fo_rptr_q + FO_PTR_ONE;
              fo_count_d = fo_count_q - FO_CNT_ONE;
            end
            G_MW: begin
              addr_d     = FO_BASE_A + ADDR_W'(fo_wptr_q);
              wdata_d    = master_wdata;
              fo_wptr_d  = fo_wptr_q + FO_PTR_ONE;
              fo_count_d = fo_count_q + FO_CNT_ONE;
            end
            default: begin
              addr_d     = FI_BASE_A + ADDR_W'(fi_rptr_q);
              fi_rptr_d  = fi_rptr_q + FI_PTR_ONE;
              fi_count_d = fi_count_q - FI_CNT_ONE;
            end
          endcase
        end
      end
      S_SETUP: acc_cnt_d = '0;
      S_ACCESS: begin
        acc_cnt_d = acc_cnt_q + 3'd1;
        // Sample the SRAM at the edge that closes the last access cycle.
        if (acc_done && !is_write) rd_cap_d = mem_dq;
      end
      S_RELEASE: begin
        if (grant_q == G_SR) slave_rdata_d  = rd_cap_q;
        if (grant_q == G_MR) master_rdata_d = rd_cap_q;
      end
      default: ;
    endcase
  end

  // Reset also discards any bookkeeping of an aborted transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q        <= G_SW;
      last_q         <= G_MR;
      acc_cnt_q      <= '0;
      fi_wptr_q      <= '0;
      fi_rptr_q      <= '0;
      fo_wptr_q      <= '0;
      fo_rptr_q      <= '0;
      fi_count_q     <= '0;
      fo_count_q     <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_cap_q       <= '0;
      slave_rdata_q  <= '0;
      master_rdata_q <= '0;
    end else begin
      grant_q        <= grant_d;
      last_q         <= last_d;
      acc_cnt_q      <= acc_cnt_d;
      fi_wptr_q      <= fi_wptr_d;
      fi_rptr_q      <= fi_rptr_d;
      fo_wptr_q      <= fo_wptr_d;
      fo_rptr_q      <= fo_rptr_d;
      fi_count_q     <= fi_count_d;
      fo_count_q     <= fo_count_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rd_cap_q       <= rd_cap_d;
      slave_rdata_q  <= slave_rdata_d;
      master_rdata_q <= master_rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_fifo_arbiter.sv
// tb/tb_sram_fifo_arbiter.sv - scoreboard bench for sram_fifo_arbiter with a behavioural SRAM

module tb_sram_fifo_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        slave_write, slave_read, master_write, master_read;
  logic [15:0] slave_wdata, master_wdata;
  logic [15:0] slave_rdata, master_rdata;
  logic        slave_ack, master_ack;
  logic        fifo_i_empty, fifo_i_full, fifo_i_afull;
  logic        fifo_o_empty, fifo_o_full, fifo_o_afull;
  logic [2:0]  fifo_i_count, fifo_o_count;
  logic [17:0] mem_addr;
  wire  [15:0] mem_dq;
  logic        CE_n, OE_n, WE_n, LB_n, UB_n;

  sram_fifo_arbiter #(
    .DATA_W(16), .ADDR_W(18), .FI_BASE(0), .FI_DEPTH_LOG2(2),
    .FO_BASE(16), .FO_DEPTH_LOG2(2), .ACCESS_CYCLES(1), .AFULL_LEVEL(3)
  ) dut (
    .clk(clk), .rst(rst),
    .slave_write(slave_write), .slave_read(slave_read),
    .master_write(master_write), .master_read(master_read),
    .slave_wdata(slave_wdata), .master_wdata(master_wdata),
    .slave_rdata(slave_rdata), .master_rdata(master_rdata),
    .slave_ack(slave_ack), .master_ack(master_ack),
    .fifo_i_empty(fifo_i_empty), .fifo_i_full(fifo_i_full), .fifo_i_afull(fifo_i_afull),
    .fifo_i_count(fifo_i_count),
    .fifo_o_empty(fifo_o_empty), .fifo_o_full(fifo_o_full), .fifo_o_afull(fifo_o_afull),
    .fifo_o_count(fifo_o_count),
    .mem_addr(mem_addr), .mem_dq(mem_dq),
    .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n), .LB_n(LB_n), .UB_n(UB_n)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural async SRAM
  logic [15:0] sram [0:63];
  logic [17:0] last_wr_addr = '0, last_rd_addr = '0;
  logic [15:0] last_wr_data = '0;
  assign mem_dq = (!CE_n && !OE_n) ? sram[mem_addr[5:0]] : 16'bz;
  always @(posedge clk) begin
    if (!CE_n && !WE_n) begin
      sram[mem_addr[5:0]] <= mem_dq;
      last_wr_addr        <= mem_addr;
      last_wr_data        <= mem_dq;
    end
    if (!CE_n && !OE_n) last_rd_addr <= mem_addr;
  end

  // Scoreboard: id 0=SW 1=SR 2=MW 3=MR
  typedef struct {
    int          id;
    logic [17:0] addr;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic prev_ack = 1'b0;

  task automatic expect_txn(input int id, input logic [17:0] a, input logic [15:0] d);
    exp_t x;
    x.id = id; x.addr = a; x.data = d;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (slave_ack || master_ack) begin
      check("ack_single_pulse", 32'(prev_ack), 0);
      check("ack_one_side", 32'(slave_ack & master_ack), 0);
      check("ack_has_expectation", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ack_side", 32'(master_ack), 32'(e.id >= 2));
        if (e.id == 0 || e.id == 2) begin
          check("wr_addr", 32'(last_wr_addr), 32'(e.addr));
          check("wr_data", 32'(last_wr_data), 32'(e.data));
        end else begin
          check("rd_addr", 32'(last_rd_addr), 32'(e.addr));
          check("rd_data", 32'((e.id == 1) ? slave_rdata : master_rdata), 32'(e.data));
        end
      end
    end
    prev_ack = slave_ack | master_ack;
  end

  task automatic set_req(input int id, input logic v);
    case (id)
      0:       slave_write  = v;
      1:       slave_read   = v;
      2:       master_write = v;
      default: master_read  = v;
    endcase
  endtask

  // Waits one idle cycle, raises the request, holds it until ack is seen.
  task automatic do_req(input int id, input logic [15:0] d, output int lat);
    logic done;
    @(negedge clk);
    if (id == 0) slave_wdata = d;
    if (id == 2) master_wdata = d;
    set_req(id, 1'b1);
    lat  = 0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      lat++;
      if ((id < 2) ? slave_ack : master_ack) done = 1'b1;
    end
    set_req(id, 1'b0);
    check("req_acked", 32'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat, lat2, acks;
    logic any_act;
    rst = 1'b1;
    slave_write = 0; slave_read = 0; master_write = 0; master_read = 0;
    slave_wdata = '0; master_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("reset_flags", 32'({fifo_i_empty, fifo_i_full, fifo_i_afull, fifo_o_empty, fifo_o_full, fifo_o_afull}), 32'b100100);
    check("reset_ctrl", 32'({CE_n, OE_n, WE_n, LB_n, UB_n}), 32'b11111);
    check("reset_counts", 32'({fifo_i_count, fifo_o_count}), 0);
    check("reset_acks_addr", 32'({slave_ack, master_ack, mem_addr}), 0);
    check("reset_rdata", 32'({slave_rdata, master_rdata}), 0);

    // Single write then read back, latency T+3+ACCESS_CYCLES
    expect_txn(0, 18'd0, 16'hA5A5);
    do_req(0, 16'hA5A5, lat);
    check("sw_latency", 32'(lat), 4);
    check("fi_count_after_sw", 32'({fifo_i_count, fifo_i_empty}), 32'b0010);
    expect_txn(3, 18'd0, 16'hA5A5);
    do_req(3, 16'h0, lat);
    check("mr_latency", 32'(lat), 4);
    check("fi_count_after_mr", 32'({fifo_i_count, fifo_i_empty}), 32'b0001);

    // MR on empty fifo_i is held off until a SW lands
    expect_txn(0, 18'd1, 16'h1234);
    expect_txn(3, 18'd1, 16'h1234);
    fork
      do_req(3, 16'h0, lat);
      begin
        any_act = 1'b0;
        repeat (10) begin
          @(negedge clk);
          any_act = any_act | master_ack | ~CE_n;
        end
        check("mr_held_off_when_empty", 32'(any_act), 0);
        do_req(0, 16'h1234, lat2);
      end
    join
    check("fi_empty_after_mr", 32'(fifo_i_empty), 1);

    // Reset clears read data; then fill fifo_i to full and wrap
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rdata_cleared_by_reset", 32'(master_rdata), 0);
    for (int k = 1; k <= 3; k++) begin
      expect_txn(0, 18'(k - 1), 16'(k));
      do_req(0, 16'(k), lat);
    end
    check("afull_at_3", 32'({fifo_i_afull, fifo_i_full, fifo_i_count}), 32'b10011);
    expect_txn(0, 18'd3, 16'd4);
    do_req(0, 16'd4, lat);
    check("full_at_4", 32'({fifo_i_afull, fifo_i_full, fifo_i_count}), 32'b11100);
    @(negedge clk);
    slave_wdata = 16'h0099;
    slave_write = 1'b1;
    any_act = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any_act = any_act | slave_ack | ~CE_n;
    end
    slave_write = 1'b0;
    check("sw_held_off_when_full", 32'(any_act), 0);
    check("count_still_4", 32'(fifo_i_count), 4);
    expect_txn(3, 18'd0, 16'd1);
    do_req(3, 16'h0, lat);
    expect_txn(0, 18'd0, 16'd5);
    do_req(0, 16'd5, lat);
    for (int k = 0; k < 4; k++) begin
      expect_txn(3, 18'((k + 1) % 4), 16'(k + 2));
      do_req(3, 16'h0, lat);
    end
    check("fi_drained", 32'({fifo_i_empty, fifo_i_count}), 32'b1000);

    // Round robin: preload both FIFOs to 2 words with MR as last grant
    expect_txn(2, 18'd16, 16'hB001); do_req(2, 16'hB001, lat);
    expect_txn(2, 18'd17, 16'hB002); do_req(2, 16'hB002, lat);
    expect_txn(0, 18'd1, 16'hC001);  do_req(0, 16'hC001, lat);
    expect_txn(0, 18'd2, 16'hC002);  do_req(0, 16'hC002, lat);
    expect_txn(0, 18'd3, 16'hC003);  do_req(0, 16'hC003, lat);
    expect_txn(3, 18'd1, 16'hC001);  do_req(3, 16'h0, lat);
    check("rr_preload", 32'({fifo_i_count, fifo_o_count}), 32'b010010);
    expect_txn(0, 18'd0,  16'h5A01);
    expect_txn(1, 18'd16, 16'hB001);
    expect_txn(2, 18'd18, 16'h6B02);
    expect_txn(3, 18'd2,  16'hC002);
    expect_txn(0, 18'd1,  16'h5A01);
    @(negedge clk);
    slave_wdata = 16'h5A01;
    master_wdata = 16'h6B02;
    slave_write = 1; slave_read = 1; master_write = 1; master_read = 1;
    acks = 0;
    for (int i = 0; i < 100 && acks < 5; i++) begin
      @(negedge clk);
      if (slave_ack || master_ack) acks++;
    end
    slave_write = 0; slave_read = 0; master_write = 0; master_read = 0;
    check("rr_ack_count", 32'(acks), 5);
    check("rr_counts", 32'({fifo_i_count, fifo_o_count}), 32'b011010);

    // Reset in the ACCESS cycle of a write aborts it
    @(negedge clk);
    slave_wdata = 16'h7777;
    slave_write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("we_low_in_access", 32'({WE_n, OE_n, CE_n}), 32'b010);
    rst = 1'b1;
    slave_write = 1'b0;
    @(negedge clk);
    check("abort_ctrl", 32'({CE_n, OE_n, WE_n, slave_ack}), 32'b1110);
    check("abort_counts", 32'({fifo_i_count, fifo_o_count, fifo_i_empty}), 32'b0000001);
    check("abort_rdata_addr", 32'({slave_rdata, master_rdata}) | 32'(mem_addr), 0);
    rst = 1'b0;
    expect_txn(0, 18'd0, 16'h8888);
    do_req(0, 16'h8888, lat);
    expect_txn(3, 18'd0, 16'h8888);
    do_req(3, 16'h0, lat);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
